// File: rtl/rf_write_buffer.sv
// In-order write-back queue in front of the 16x32 register file: drains one write per
// cycle into the RF write port and exposes a combinational bypass lookup over queued entries.
module rf_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rf_stall,
    output logic                     rf_ld,
    output logic [ADDR_W-1:0]        rf_sel,
    output logic [DATA_W-1:0]        rf_data,
    input  logic [ADDR_W-1:0]        lk_addr,
    output logic                     lk_hit,
    output logic [DATA_W-1:0]        lk_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  vld_q;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic              push;
    logic              pop;
    logic [PTR_W-1:0]  idx;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    // Ready depends only on registered occupancy, never on a same-cycle pop.
    assign wr_ready = !full && !rst;
    assign rf_ld    = !empty && !rf_stall && !rst;
    assign push     = wr_valid && wr_ready;
    assign pop      = rf_ld;
    assign rf_sel   = empty ? '0 : addr_q[head];
    assign rf_data  = empty ? '0 : data_q[head];

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            vld_q <= '0;
        end else begin
            if (push) begin
                tail        <= tail + PTR_W'(1);
                vld_q[tail] <= 1'b1;
            end
            if (pop) begin
                head        <= head + PTR_W'(1);
                vld_q[head] <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage carries no reset; validity is tracked by vld_q.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail] <= wr_addr;
            data_q[tail] <= wr_data;
        end
    end

    // Walk oldest to youngest so the last match seen is the youngest.
    always_comb begin
        lk_hit  = 1'b0;
        lk_data = '0;
        idx     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PTR_W'(k);
            if (vld_q[idx] && (addr_q[idx] == lk_addr)) begin
                lk_hit  = 1'b1;
                lk_data = data_q[idx];
            end
        end
    end

endmodule

// File: tb/tb_rf_write_buffer.sv
// Directed self-checking bench for rf_write_buffer with hand-computed expectations.
module tb_rf_write_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_valid;
    logic        wr_ready;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rf_stall;
    logic        rf_ld;
    logic [3:0]  rf_sel;
    logic [31:0] rf_data;
    logic [3:0]  lk_addr;
    logic        lk_hit;
    logic [31:0] lk_data;
    logic [2:0]  count;
    logic        full;
    logic        empty;

    int n_assert = 0;
    int n_fail   = 0;

    rf_write_buffer #(.DEPTH(4), .ADDR_W(4), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rf_stall(rf_stall), .rf_ld(rf_ld), .rf_sel(rf_sel), .rf_data(rf_data),
        .lk_addr(lk_addr), .lk_hit(lk_hit), .lk_data(lk_data),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        rf_stall = 1'b0; lk_addr = '0;

        // 1. Reset and idle
        tick(); tick();
        chk("rst_wr_ready", 32'(wr_ready), 0);
        chk("rst_rf_ld", 32'(rf_ld), 0);
        rst = 1'b0; #1;
        chk("idle_empty", 32'(empty), 1);
        chk("idle_full", 32'(full), 0);
        chk("idle_count", 32'(count), 0);
        chk("idle_wr_ready", 32'(wr_ready), 1);
        chk("idle_rf_ld", 32'(rf_ld), 0);
        chk("idle_rf_sel", 32'(rf_sel), 0);
        chk("idle_rf_data", rf_data, 0);
        chk("idle_lk_hit", 32'(lk_hit), 0);
        chk("idle_lk_data", lk_data, 0);
        tick();

        // 2. Single write passes through with one-cycle latency
        wr_valid = 1'b1; wr_addr = 4'd3; wr_data = 32'hDEADBEEF; lk_addr = 4'd3; #1;
        chk("t2_push_not_searched", 32'(lk_hit), 0);
        tick();
        wr_valid = 1'b0; #1;
        chk("t2_rf_ld", 32'(rf_ld), 1);
        chk("t2_rf_sel", 32'(rf_sel), 3);
        chk("t2_rf_data", rf_data, 32'hDEADBEEF);
        chk("t2_count", 32'(count), 1);
        chk("t2_lk_hit", 32'(lk_hit), 1);
        chk("t2_lk_data", lk_data, 32'hDEADBEEF);
        tick();
        chk("t2_empty_after", 32'(empty), 1);
        chk("t2_rf_ld_after", 32'(rf_ld), 0);

        // 3. Fill while stalled, hold a fifth request, then drain in order
        rf_stall = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            wr_valid = 1'b1; wr_addr = 4'(i); wr_data = 32'(i * 32'h11);
            tick();
        end
        wr_addr = 4'd9; wr_data = 32'h99; #1;
        chk("t3_full", 32'(full), 1);
        chk("t3_count_full", 32'(count), 4);
        chk("t3_wr_ready_full", 32'(wr_ready), 0);
        chk("t3_rf_ld_stalled", 32'(rf_ld), 0);
        tick();
        chk("t3_count_held", 32'(count), 4);
        rf_stall = 1'b0; #1;
        chk("t3_pop1_ld", 32'(rf_ld), 1);
        chk("t3_pop1_sel", 32'(rf_sel), 1);
        chk("t3_pop1_data", rf_data, 32'h11);
        chk("t3_pop1_wr_ready", 32'(wr_ready), 0);
        tick();
        chk("t3_pop2_sel", 32'(rf_sel), 2);
        chk("t3_pop2_data", rf_data, 32'h22);
        chk("t3_pop2_count", 32'(count), 3);
        chk("t3_pop2_wr_ready", 32'(wr_ready), 1);
        tick();
        wr_valid = 1'b0; #1;
        chk("t3_pop3_sel", 32'(rf_sel), 3);
        chk("t3_pop3_data", rf_data, 32'h33);
        chk("t3_pop3_count", 32'(count), 3);
        tick();
        chk("t3_pop4_sel", 32'(rf_sel), 4);
        chk("t3_pop4_data", rf_data, 32'h44);
        chk("t3_pop4_count", 32'(count), 2);
        tick();
        chk("t3_pop5_sel", 32'(rf_sel), 9);
        chk("t3_pop5_data", rf_data, 32'h99);
        chk("t3_pop5_count", 32'(count), 1);
        tick();
        chk("t3_drained", 32'(empty), 1);

        // 4. Lookup returns the youngest match
        rf_stall = 1'b1;
        wr_valid = 1'b1; wr_addr = 4'd5; wr_data = 32'hA; tick();
        wr_addr = 4'd7; wr_data = 32'hB; tick();
        wr_addr = 4'd5; wr_data = 32'hC; tick();
        wr_valid = 1'b0; lk_addr = 4'd5; #1;
        chk("t4_lk5_hit", 32'(lk_hit), 1);
        chk("t4_lk5_data", lk_data, 32'hC);
        lk_addr = 4'd7; #1;
        chk("t4_lk7_data", lk_data, 32'hB);
        lk_addr = 4'd6; #1;
        chk("t4_lk6_hit", 32'(lk_hit), 0);
        chk("t4_lk6_data", lk_data, 0);
        wr_valid = 1'b1; wr_addr = 4'd6; wr_data = 32'hD; #1;
        chk("t4_lk6_pushing", 32'(lk_hit), 0);
        tick();
        wr_valid = 1'b0; #1;
        chk("t4_lk6_queued", lk_data, 32'hD);
        rf_stall = 1'b0; lk_addr = 4'd5;
        tick(); tick();
        chk("t4_popping_sel", 32'(rf_sel), 5);
        chk("t4_popping_ld", 32'(rf_ld), 1);
        chk("t4_popping_hit", 32'(lk_hit), 1);
        chk("t4_popping_data", lk_data, 32'hC);
        tick(); tick();
        chk("t4_drained", 32'(empty), 1);

        // 5. Back-to-back stream wraps the pointers
        for (int i = 0; i < 20; i++) begin
            wr_valid = 1'b1; wr_addr = 4'(i % 16); wr_data = 32'h1000 + 32'(i);
            tick();
            chk("t5_ld", 32'(rf_ld), 1);
            chk("t5_sel", 32'(rf_sel), 32'(i % 16));
            chk("t5_data", rf_data, 32'h1000 + 32'(i));
            chk("t5_count", 32'(count), 1);
        end
        wr_valid = 1'b0;
        tick();
        chk("t5_drained", 32'(empty), 1);

        // 6. Reset discards queued writes
        rf_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1; wr_addr = 4'(10 + i); wr_data = 32'hA0 + 32'(i);
            tick();
        end
        wr_valid = 1'b0; #1;
        chk("t6_count3", 32'(count), 3);
        rf_stall = 1'b0; rst = 1'b1; lk_addr = 4'd10; #1;
        chk("t6_ld_in_rst", 32'(rf_ld), 0);
        chk("t6_ready_in_rst", 32'(wr_ready), 0);
        tick();
        rst = 1'b0; #1;
        chk("t6_count0", 32'(count), 0);
        chk("t6_empty", 32'(empty), 1);
        chk("t6_sel", 32'(rf_sel), 0);
        chk("t6_lk_hit", 32'(lk_hit), 0);
        for (int i = 0; i < 4; i++) begin
            chk("t6_no_ld", 32'(rf_ld), 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
